// File: rtl/shift_seq_pkg.sv
// Shared types and encodings for the shift-register sequencing controller.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHUP = 2'b01;
    localparam logic [1:0] OP_SHDN = 2'b10;
    localparam logic [1:0] OP_ROTU = 2'b11;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam int unsigned SER_W = 7;

    // Register mode used while executing a given operation.
    function automatic logic [1:0] op_mode(input logic [1:0] op);
        case (op)
            OP_LOAD: return MODE_LOAD;
            OP_SHDN: return MODE_DOWN;
            default: return MODE_UP;
        endcase
    endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Shift-step counter: cleared on load, advances on enable, saturates at the limit.
module shift_step_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;

    assign count_o = count_q;
    assign tc_o    = (count_q == limit_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (en_i && !tc_o) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a universal shift register: load, shift up/down, rotate up.
// Every output is registered, so each value is computed for the state being entered.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [SER_W-1:0] cmd_ser,
    input  logic [WIDTH-1:0] q_fb,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] p_din,
    output logic             s_left,
    output logic             s_right,
    output logic             busy,
    output logic             done
);

    state_e state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [SER_W-1:0] ser_q, ser_d;

    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] p_din_q, p_din_d;
    logic             s_left_q, s_left_d;
    logic             s_right_q, s_right_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt, step_nxt;
    logic             rot_next_msb;

    shift_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .limit_i (n_q - CNT_W'(1)),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    assign step_nxt = cnt + CNT_W'(1);
    // While shifting up, the register's MSB after this edge is today's bit WIDTH-2.
    assign rot_next_msb = |(q_fb & (WIDTH'(1) << (WIDTH - 2)));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        n_d       = n_q;
        ser_d     = ser_q;
        s_d       = MODE_HOLD;
        p_din_d   = '0;
        s_left_d  = 1'b0;
        s_right_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b1;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    n_d     = cmd_count;
                    ser_d   = cmd_ser;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    if (cmd_op == OP_LOAD) begin
                        state_d = StLoad;
                        s_d     = MODE_LOAD;
                        p_din_d = cmd_data;
                    end else if (cmd_count == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StShift;
                        cnt_load = 1'b1;
                        s_d      = op_mode(cmd_op);
                        unique case (cmd_op)
                            OP_SHUP: s_left_d  = cmd_ser[0];
                            OP_SHDN: s_right_d = cmd_ser[0];
                            default: s_left_d  = q_fb[WIDTH-1];
                        endcase
                    end
                end
            end
            StLoad: begin
                state_d = StDone;
                done_d  = 1'b1;
                busy_d  = 1'b1;
                ready_d = 1'b0;
            end
            StShift: begin
                cnt_en  = 1'b1;
                busy_d  = 1'b1;
                ready_d = 1'b0;
                if (cnt_tc) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    s_d = op_mode(op_q);
                    unique case (op_q)
                        OP_SHUP: s_left_d  = ser_q[step_nxt];
                        OP_SHDN: s_right_d = ser_q[step_nxt];
                        default: s_left_d  = rot_next_msb;
                    endcase
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            n_q       <= '0;
            ser_q     <= '0;
            s_q       <= MODE_HOLD;
            p_din_q   <= '0;
            s_left_q  <= 1'b0;
            s_right_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            n_q       <= n_d;
            ser_q     <= ser_d;
            s_q       <= s_d;
            p_din_q   <= p_din_d;
            s_left_q  <= s_left_d;
            s_right_q <= s_right_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign s         = s_q;
    assign p_din     = p_din_q;
    assign s_left    = s_left_q;
    assign s_right   = s_right_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a behavioural 4-bit universal shift register closes the loop,
// and each command's cycle trace and final register value are predicted from the op rules.
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic [6:0] cmd_ser;
    logic [3:0] q_fb;
    logic [1:0] s;
    logic [3:0] p_din;
    logic       s_left;
    logic       s_right;
    logic       busy;
    logic       done;

    logic [3:0]  dev_q;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] IDLE_VEC = {2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [10:0] DONE_VEC = {2'b11, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    shift_seq_ctrl #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .cmd_ser   (cmd_ser),
        .q_fb      (q_fb),
        .s         (s),
        .p_din     (p_din),
        .s_left    (s_left),
        .s_right   (s_right),
        .busy      (busy),
        .done      (done)
    );

    // The driven register: 00 load, 01 up (s_left into bit 0), 10 down (s_right into bit 3).
    always @(posedge clk) begin
        case (s)
            2'b00:   dev_q <= p_din;
            2'b01:   dev_q <= {dev_q[2:0], s_left};
            2'b10:   dev_q <= {s_right, dev_q[3:1]};
            default: dev_q <= dev_q;
        endcase
    end

    assign q_fb = dev_q;
    assign obs  = {s, p_din, s_left, s_right, busy, done, cmd_ready};

    // Issues one command from a negedge and checks every cycle until back in idle.
    task automatic test_cmd(input string name, input logic [1:0] op, input int n,
                            input logic [3:0] data, input logic [6:0] ser, input bit hold);
        logic [3:0]  q0, qm;
        logic [10:0] exp;
        logic [1:0]  es;
        logic        esl, esr;
        int          w, nmode, idx;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: cmd_ready=%b required 1", name, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        q0        = dev_q;
        cmd_op    = op;
        cmd_count = 3'(n);
        cmd_data  = data;
        cmd_ser   = ser;
        cmd_valid = 1'b1;
        @(posedge clk);
        nmode = (op == 2'b00) ? 1 : n;
        for (int k = 0; k < nmode; k++) begin
            @(negedge clk);
            if (hold) begin
                cmd_op   = 2'b00;
                cmd_data = 4'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            es  = (op == 2'b00) ? 2'b00 : (op == 2'b10) ? 2'b10 : 2'b01;
            esl = 1'b0;
            esr = 1'b0;
            if (op == 2'b01) esl = ser[k];
            if (op == 2'b10) esr = ser[k];
            if (op == 2'b11) begin
                idx = (W - 1 - (k % W) + W) % W;
                esl = q0[idx];
            end
            exp = {es, (op == 2'b00) ? data : 4'b0000, esl, esr, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s step%0d: {s,p_din,sl,sr,busy,done,rdy}=%b required %b",
                         name, k, obs, exp);
            end
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        checks++;
        if (obs !== DONE_VEC) begin
            errors++;
            $display("FAIL %s done_cycle: outputs=%b required %b", name, obs, DONE_VEC);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL %s idle_after: outputs=%b required %b", name, obs, IDLE_VEC);
        end
        qm = q0;
        case (op)
            2'b00: qm = data;
            2'b01: for (int k = 0; k < n; k++) qm = {qm[2:0], ser[k]};
            2'b10: for (int k = 0; k < n; k++) qm = {ser[k], qm[3:1]};
            default: for (int k = 0; k < n; k++) qm = {qm[2:0], qm[3]};
        endcase
        checks++;
        if (dev_q !== qm) begin
            errors++;
            $display("FAIL %s register: got %b required %b", name, dev_q, qm);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = 3'd0;
        cmd_data  = 4'd0;
        cmd_ser   = 7'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_state: outputs=%b required %b", obs, IDLE_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release: outputs=%b required %b", obs, IDLE_VEC);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        cmd_op    = 2'b01;
        cmd_count = 3'd7;
        cmd_ser   = 7'b1010101;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL abort_reset: outputs=%b required %b", obs, IDLE_VEC);
        end
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: done/busy cycles=%0d required 0", dones);
        end
        // Reset must win over a handshake offered on the same edge.
        cmd_op    = 2'b00;
        cmd_data  = 4'b1111;
        cmd_valid = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL rst_priority: outputs=%b required %b", obs, IDLE_VEC);
        end
        @(negedge clk);
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL rst_priority_after: outputs=%b required %b", obs, IDLE_VEC);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        int         n;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 7));
            test_cmd("random", op, n, 4'($urandom), 7'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_cmd("load_1010", 2'b00, 0, 4'b1010, 7'd0, 1'b0);
        test_cmd("load_0000", 2'b00, 0, 4'b0000, 7'd0, 1'b0);
        test_cmd("shift_up_3", 2'b01, 3, 4'b0000, 7'b0000101, 1'b0);
        test_cmd("shift_down_7", 2'b10, 7, 4'b0000, 7'b1111111, 1'b0);
        test_cmd("load_1001", 2'b00, 0, 4'b1001, 7'd0, 1'b0);
        test_cmd("rotate_4", 2'b11, 4, 4'b0000, 7'd0, 1'b0);
        test_cmd("rotate_7", 2'b11, 7, 4'b0000, 7'd0, 1'b0);
        test_cmd("zero_count", 2'b01, 0, 4'b0000, 7'b1111111, 1'b0);
        test_cmd("valid_held", 2'b10, 5, 4'b0000, 7'b0110101, 1'b1);
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the width of the driven 4-bit universal shift register.
REQ-002 SHALL have parameter CNT_W, default 3, meaning the width of the shift-count field (maximum count 7).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  operation: 00 LOAD, 01 SHIFT_UP, 10 SHIFT_DOWN, 11 ROTATE_UP.
REQ-008 cmd_count  input  CNT_W  number of shift steps (ignored for LOAD).
REQ-009 cmd_data  input  WIDTH  parallel load word.
REQ-010 cmd_ser  input  7  serial bits for shift ops, LSB consumed first.
REQ-011 q_fb  input  WIDTH  feedback from the shift register parallel output.
REQ-012 s  output  2  register mode: 00 load, 01 shift up (s_left enters bit 0), 10 shift down (s_right enters bit 3), 11 hold.
REQ-013 p_din  output  WIDTH  parallel data to the register.
REQ-014 s_left / s_right  output  1 each  serial inputs to the register.
REQ-015 busy  output  1  command in progress.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; all outputs registered.
REQ-018 IDLE: cmd_ready=1, busy=0, s=11; handshake on cmd_valid&&cmd_ready captures op, count, data and ser.
REQ-019 IDLE->LOAD for op 00: one cycle with s=00 and p_din=captured data, then DONE.
REQ-020 IDLE->SHIFT for ops 01/10/11 with count N>0: exactly N cycles of s=01 (ops 01, 11) or s=10 (op 10), then DONE.
REQ-021 IDLE->DONE directly for a shift op with N=0; the register is never shifted.
REQ-022 In SHIFT step k (0..N-1): op 01 drives s_left=ser[k]; op 10 drives s_right=ser[k]; op 11 drives s_left=q_fb[WIDTH-1] sampled that cycle.
REQ-023 The unused serial input and p_din SHALL be 0 outside their active states.
REQ-024 DONE: s=11, done=1 for exactly one cycle, then IDLE.
REQ-025 busy=1 and cmd_ready=0 in LOAD, SHIFT, DONE; cmd_valid in those states is ignored, not queued.
REQ-026 Latency: handshake at edge E -> first mode cycle follows E -> done high in the cycle after the last mode cycle; command-to-command minimum spacing is N+2 cycles (LOAD: 3).
REQ-027 Step counter SHALL count 0..N-1 and never wrap; N=7 is the boundary case.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE, s=11, p_din=0, s_left=0, s_right=0, busy=0, done=0, cmd_ready=1, counter and captured fields 0.
REQ-029 rst SHALL abort any in-progress command with no done pulse; rst has priority over a simultaneous handshake.

Structure
REQ-030 Package shift_seq_pkg SHALL hold the state enum, the op codes (OP_LOAD, OP_SHUP, OP_SHDN, OP_ROTU) and the register mode codes (MODE_LOAD, MODE_UP, MODE_DOWN, MODE_HOLD).
REQ-031 The step counter SHALL be the single sub-module shift_step_counter (load, enable, terminal-count output).

Verification
REQ-032 LOAD data=1010 -> one cycle s=00, p_din=1010; done pulses 2 cycles after handshake; register reads 1010.
REQ-033 SHIFT_UP N=3, ser=…101, register 0000 -> s=01 for 3 cycles, s_left=1,0,1; register 0101; done once.
REQ-034 SHIFT_DOWN N=7, ser=1111111 -> 7 cycles of s=10, s_right=1; register 1111; no counter wrap.
REQ-035 ROTATE_UP N=4 from 1001 -> register returns to 1001; N=0 shift -> done the cycle after handshake, s stays 11.
REQ-036 cmd_valid held high during SHIFT -> not accepted until IDLE; rst asserted mid-SHIFT -> next cycle s=11, busy=0, no done.
